// File: rtl/magnitude_comparator_seq.sv
// rtl/magnitude_comparator_seq.sv - chunk-serial magnitude comparator, MSB slice first (optional CMP_SIGNED_EN)
module magnitude_comparator_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, next_state;

  // Captured operands are shifted left one slice per equal compare, so the
  // slice under test always sits in the top CHUNK bits.
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] a_cap, b_cap;
  logic [IDXW-1:0]  idx;
  logic [CHUNK-1:0] slice_a, slice_b;
  logic             last_slice;
  logic             load, step, finish_ne, finish_eq;

  assign slice_a    = a_q[WIDTH-1 -: CHUNK];
  assign slice_b    = b_q[WIDTH-1 -: CHUNK];
  assign last_slice = (idx == LAST_IDX);

  // Operand conditioning at capture: flipping the sign bit maps two's-complement
  // order onto unsigned order, so the slice compare stays unsigned.
  always_comb begin
    a_cap = a;
    b_cap = b;
`ifdef CMP_SIGNED_EN
    if (signed_mode) begin
      a_cap[WIDTH-1] = ~a[WIDTH-1];
      b_cap[WIDTH-1] = ~b[WIDTH-1];
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode, datapath controls and status outputs.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    finish_ne  = 1'b0;
    finish_eq  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = COMPARE;
        end
      end
      COMPARE: begin
        busy = 1'b1;
        if (slice_a != slice_b) begin
          finish_ne  = 1'b1;
          next_state = DONE;
        end else if (last_slice) begin
          finish_eq  = 1'b1;
          next_state = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          next_state = COMPARE;
        end else begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operand capture, slice walk and result flag update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      a_gt_b <= 1'b0;
      a_lt_b <= 1'b0;
      a_eq_b <= 1'b0;
    end else begin
      if (load) begin
        a_q <= a_cap;
        b_q <= b_cap;
        idx <= '0;
      end else if (step) begin
        a_q <= a_q << CHUNK;
        b_q <= b_q << CHUNK;
        idx <= idx + 1'b1;
      end
      if (finish_ne) begin
        a_gt_b <= (slice_a > slice_b);
        a_lt_b <= (slice_a < slice_b);
        a_eq_b <= 1'b0;
      end else if (finish_eq) begin
        a_gt_b <= 1'b0;
        a_lt_b <= 1'b0;
        a_eq_b <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_magnitude_comparator_seq.sv
// tb/tb_magnitude_comparator_seq.sv - directed self-checking bench for magnitude_comparator_seq
module tb_magnitude_comparator_seq;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef CMP_SIGNED_EN
  logic         signed_mode;
`endif
  logic         busy;
  logic         done;
  logic         a_gt_b;
  logic         a_lt_b;
  logic         a_eq_b;

  int compared;
  int mismatched;

  magnitude_comparator_seq #(.WIDTH(W), .CHUNK(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
`ifdef CMP_SIGNED_EN
    .signed_mode (signed_mode),
`endif
    .busy        (busy),
    .done        (done),
    .a_gt_b      (a_gt_b),
    .a_lt_b      (a_lt_b),
    .a_eq_b      (a_eq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] flags();
    return {a_gt_b, a_lt_b, a_eq_b};
  endfunction

  // One comparison: start pulse, count edges to done, check flags, pulse width
  // and hold. With inject set, a conflicting start is raised while busy.
  task automatic run_cmp(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input int exp_k, input logic [2:0] exp_flags, input bit inject);
    int n;
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, "/busy_after_start"}, 32'(busy), 32'd1);
    if (inject) begin
      a = 16'h0000;
      b = 16'hFFFF;
      start = 1'b1;
    end else begin
      a = 16'($urandom);
      b = 16'($urandom);
    end
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      start = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      n++;
    end
    check({tag, "/latency"}, 32'(n), 32'(exp_k));
    check({tag, "/flags"}, 32'(flags()), 32'(exp_flags));
    check({tag, "/busy_at_done"}, 32'(busy), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check({tag, "/done_pulse_ends"}, 32'(done), 32'd0);
      check({tag, "/flags_hold"}, 32'(flags()), 32'(exp_flags));
    end
  endtask

  initial begin
    int n;
    compared   = 0;
    mismatched = 0;
    rst   = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
`ifdef CMP_SIGNED_EN
    signed_mode = 1'b0;
`endif

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("reset_outputs", 32'({busy, done, a_gt_b, a_lt_b, a_eq_b}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 32'({busy, done, a_gt_b, a_lt_b, a_eq_b}), 32'd0);

    // First-slice decision, full-length lt and eq.
    run_cmp("e000_a000", 16'hE000, 16'hA000, 1, 3'b100, 1'b0);
    run_cmp("1234_1235", 16'h1234, 16'h1235, 4, 3'b010, 1'b0);
    run_cmp("beef_beef", 16'hBEEF, 16'hBEEF, 4, 3'b001, 1'b0);

    // Start while busy is ignored: the injected 0000/FFFF would give lt.
    run_cmp("ignored_start", 16'h5B00, 16'h5A00, 2, 3'b100, 1'b1);

    // Unsigned ordering of the sign bit in the default mode.
    run_cmp("8000_0001_unsigned", 16'h8000, 16'h0001, 1, 3'b100, 1'b0);
`ifdef CMP_SIGNED_EN
    signed_mode = 1'b1;
    run_cmp("8000_0001_signed", 16'h8000, 16'h0001, 1, 3'b010, 1'b0);
    signed_mode = 1'b0;
`endif

    // Back-to-back: start stays high through the DONE cycle with new operands.
    @(negedge clk);
    a = 16'hE000;
    b = 16'hA000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 16'h0F00;
    b = 16'h0E00;
    check("b2b/first_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("b2b/first_done", 32'(done), 32'd1);
    check("b2b/first_flags", 32'(flags()), 32'(3'b100));
    @(negedge clk);
    start = 1'b0;
    a = 16'h0000;
    b = 16'hFFFF;
    check("b2b/second_busy", 32'(busy), 32'd1);
    check("b2b/second_no_done", 32'(done), 32'd0);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b/second_latency", 32'(n), 32'd2);
    check("b2b/second_flags", 32'(flags()), 32'(3'b100));
    @(negedge clk);
    check("b2b/idle_after", 32'({busy, done}), 32'd0);

    // Reset in the second COMPARE cycle aborts with no done pulse.
    @(negedge clk);
    a = 16'h1234;
    b = 16'h1235;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rst_mid/busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid/outputs_cleared", 32'({busy, done, a_gt_b, a_lt_b, a_eq_b}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) n++;
    end
    check("rst_mid/no_done", 32'(n), 32'd0);
    run_cmp("after_rst_0007", 16'h0007, 16'h0007, 4, 3'b001, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global time bound so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/magnitude_comparator_seq.md
MAGNITUDE_COMPARATOR_SEQ -- requirements
Module: magnitude_comparator_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a positive multiple of CHUNK.
REQ-002 Parameter CHUNK, default 4, bits compared per cycle; NCHUNK = WIDTH/CHUNK.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port start  input  1  request; sampled only when the block can accept it.
REQ-006 Port a  input  WIDTH  operand A; sampled with start.
REQ-007 Port b  input  WIDTH  operand B; sampled with start.
REQ-008 Port signed_mode  input  1  two's-complement compare when 1; exists only with CMP_SIGNED_EN.
REQ-009 Port busy  output  1  high while a comparison is in progress.
REQ-010 Port done  output  1  one-cycle pulse: result flags updated this cycle.
REQ-011 Port a_gt_b  output  1  registered result, A > B.
REQ-012 Port a_lt_b  output  1  registered result, A < B.
REQ-013 Port a_eq_b  output  1  registered result, A == B.

Function
REQ-014 FSM states SHALL be IDLE, COMPARE and DONE.
REQ-015 IDLE: on a rising edge with start=1, the block SHALL capture a, b (and signed_mode), set chunk index to 0 and go to COMPARE.
REQ-016 COMPARE: each cycle SHALL compare one CHUNK-bit slice, MSB slice first (index 0 = bits WIDTH-1..WIDTH-CHUNK).
REQ-017 Slice-compare outcomes:
- Slices differ: the block SHALL load gt/lt from that slice, clear eq and go to DONE (early termination).
- Slices equal, not last: the block SHALL increment the index.
- Slices equal, last: the block SHALL set eq, clear gt/lt and go to DONE.
REQ-018 Latency: done SHALL be high in the cycle following the k-th clock edge after the start-sampling edge, where k is the number of slices examined (1..NCHUNK).
REQ-019 DONE SHALL last exactly one cycle, with done=1, then return to IDLE unless start=1, in which case the block SHALL accept the new operands and go to COMPARE (back-to-back).
REQ-020 busy SHALL be 1 in COMPARE and 0 in IDLE and DONE.
REQ-021 start SHALL be ignored while in COMPARE; captured operands SHALL NOT change mid-comparison.
REQ-022 Result flags SHALL hold their values until the next done; after the first done, exactly one flag SHALL be high.
REQ-023 Input changes on a and b outside the sampling edge SHALL NOT affect the result.

Reset
REQ-024 While rst=1, the block SHALL force the FSM to IDLE and busy, done, a_gt_b, a_lt_b and a_eq_b to 0 asynchronously, without waiting for clk.
REQ-025 Reset asserted mid-COMPARE SHALL abort the comparison with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-026 Macro CMP_SIGNED_EN defined: the signed_mode port SHALL exist; when the captured signed_mode=1, the block SHALL invert the sign bit (bit WIDTH-1) of both operands before the slice compare, giving two's-complement ordering.
REQ-027 Macro CMP_SIGNED_EN undefined: the signed_mode port SHALL be absent and all compares SHALL be unsigned.

Verification (WIDTH=16, CHUNK=4)
REQ-028 a=16'hE000, b=16'hA000, start pulse -> done 1 cycle after the sampling edge, a_gt_b=1, others 0.
REQ-029 a=16'h1234, b=16'h1235 -> done after 4 slices, a_lt_b=1; a=b=16'hBEEF -> done after 4 slices, a_eq_b=1.
REQ-030 start re-asserted with a=16'h0000, b=16'hFFFF while busy=1 -> ignored; the original result is reported and the flags are unchanged by the ignored request.
REQ-031 CMP_SIGNED_EN defined: a=16'h8000, b=16'h0001 -> a_lt_b=1 with signed_mode=1; a_gt_b=1 with signed_mode=0.
REQ-032 rst asserted during the 2nd COMPARE cycle of a=16'h1234, b=16'h1235 -> all outputs 0 immediately, no done pulse; a following start with a=b=16'h0007 -> a_eq_b=1.
REQ-033 start held high in the DONE cycle with new operands a=16'h0F00, b=16'h0E00 -> second comparison runs back-to-back, done after 2 slices, a_gt_b=1.
